// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the sequencer.
// master drives the hazard inputs; slave is the sequencer, which drives the stage enables and status.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [4:0]       IFID_RS1_Addr_i;
  logic [4:0]       IFID_RS2_Addr_i;
  logic [4:0]       IDEX_Rd_Addr_i;
  logic             IDEX_MemRead_i;
  logic             Branch_Taken_i;
  logic             Mem_Req_i;
  logic             Mem_Ready_i;
  logic             PCWrite_o;
  logic             IFID_Write_o;
  logic             IFID_Flush_o;
  logic             IDEX_Write_o;
  logic             IDEX_Bubble_o;
  logic             EXMEM_Write_o;
  logic             MEMWB_Write_o;
  logic [1:0]       State_o;
  logic             Err_o;
  logic [CNT_W-1:0] StallCount_o;
  logic [CNT_W-1:0] FlushCount_o;

  modport master (
    output start_i, IFID_RS1_Addr_i, IFID_RS2_Addr_i, IDEX_Rd_Addr_i,
           IDEX_MemRead_i, Branch_Taken_i, Mem_Req_i, Mem_Ready_i,
    input  PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o, IDEX_Bubble_o,
           EXMEM_Write_o, MEMWB_Write_o, State_o, Err_o, StallCount_o, FlushCount_o
  );

  modport slave (
    input  start_i, IFID_RS1_Addr_i, IFID_RS2_Addr_i, IDEX_Rd_Addr_i,
           IDEX_MemRead_i, Branch_Taken_i, Mem_Req_i, Mem_Ready_i,
    output PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Write_o, IDEX_Bubble_o,
           EXMEM_Write_o, MEMWB_Write_o, State_o, Err_o, StallCount_o, FlushCount_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: per-register write enables for load-use stalls, branch flushes
// and memory-wait freezes, with a memory-timeout halt and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10, HALT = 2'b11} state_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q;
  logic               err_q;
  logic [CNT_W-1:0]   stall_q, flush_q;
  logic               load_use, mem_busy, stall_inc;
  logic               pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w;

  assign load_use = hz.IDEX_MemRead_i && (hz.IDEX_Rd_Addr_i != 5'd0) &&
                    ((hz.IDEX_Rd_Addr_i == hz.IFID_RS1_Addr_i) ||
                     (hz.IDEX_Rd_Addr_i == hz.IFID_RS2_Addr_i));
  assign mem_busy = hz.Mem_Req_i && !hz.Mem_Ready_i;

  always_comb begin
    state_d   = state_q;
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    ifid_f    = 1'b0;
    idex_w    = 1'b0;
    idex_b    = 1'b0;
    exmem_w   = 1'b0;
    memwb_w   = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      IDLE: if (hz.start_i) state_d = RUN;
      RUN: begin
        if (!hz.start_i)  state_d = IDLE;
        else if (mem_busy) state_d = MEM_WAIT;
        // Freeze beats load-use, which beats the branch flush.
        if (mem_busy) begin
          stall_inc = 1'b1;
        end else if (load_use) begin
          idex_w    = 1'b1;
          idex_b    = 1'b1;
          exmem_w   = 1'b1;
          memwb_w   = 1'b1;
          stall_inc = 1'b1;
        end else begin
          pc_w    = 1'b1;
          ifid_w  = 1'b1;
          idex_w  = 1'b1;
          exmem_w = 1'b1;
          memwb_w = 1'b1;
          ifid_f  = hz.Branch_Taken_i;
        end
      end
      MEM_WAIT: begin
        stall_inc = 1'b1;
        if (hz.Mem_Ready_i)          state_d = RUN;
        else if (wait_q == WAIT_LAST) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != MEM_WAIT && state_d == MEM_WAIT) wait_q <= '0;
      else if (state_q == MEM_WAIT)                    wait_q <= wait_q + 1'b1;
      if (state_q == MEM_WAIT && state_d == HALT) err_q <= 1'b1;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (ifid_f && flush_q != '1)    flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.PCWrite_o     = pc_w;
  assign hz.IFID_Write_o  = ifid_w;
  assign hz.IFID_Flush_o  = ifid_f;
  assign hz.IDEX_Write_o  = idex_w;
  assign hz.IDEX_Bubble_o = idex_b;
  assign hz.EXMEM_Write_o = exmem_w;
  assign hz.MEMWB_Write_o = memwb_w;
  assign hz.State_o       = state_q;
  assign hz.Err_o         = err_q;
  assign hz.StallCount_o  = stall_q;
  assign hz.FlushCount_o  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int    TO  = 16;
  localparam int    CW  = 5;
  localparam longint SAT = (longint'(1) << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk_i(clk_i), .rst_i(rst_i), .hz(hif.slave));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic pc, ifid, flush, idex, bub, exmem, memwb;
    logic [1:0] st;
    logic err;
    logic [CW-1:0] sc, fc;
  } obs_t;

  obs_t q[$];
  int   n_chk = 0, n_fail = 0;

  // model state: 0 idle, 1 run, 2 waiting on memory, 3 halted
  int     m_st = 0, m_waited = 0;
  bit     m_err = 0;
  longint m_sc = 0, m_fc = 0;

  function automatic bit hazard();
    return hif.IDEX_MemRead_i && hif.IDEX_Rd_Addr_i != 0 &&
           (hif.IDEX_Rd_Addr_i == hif.IFID_RS1_Addr_i || hif.IDEX_Rd_Addr_i == hif.IFID_RS2_Addr_i);
  endfunction

  function automatic obs_t predict();
    obs_t e;
    bit frozen;
    e = '0;
    frozen = (m_st != 1) || (hif.Mem_Req_i && !hif.Mem_Ready_i);
    if (!frozen) begin
      if (hazard()) {e.pc, e.ifid, e.idex, e.bub, e.exmem, e.memwb} = 6'b001111;
      else begin
        {e.pc, e.ifid, e.idex, e.exmem, e.memwb} = 5'b11111;
        e.flush = hif.Branch_Taken_i;
      end
    end
    e.st  = 2'(m_st);
    e.err = m_err;
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    return e;
  endfunction

  function automatic obs_t sample();
    return {hif.PCWrite_o, hif.IFID_Write_o, hif.IFID_Flush_o, hif.IDEX_Write_o, hif.IDEX_Bubble_o,
            hif.EXMEM_Write_o, hif.MEMWB_Write_o, hif.State_o, hif.Err_o, hif.StallCount_o, hif.FlushCount_o};
  endfunction

  task automatic model_reset();
    m_st = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_step();
    obs_t e;
    bit   stalled;
    e = predict();
    stalled = (m_st == 2) || (m_st == 1 && (hazard() || (hif.Mem_Req_i && !hif.Mem_Ready_i)));
    if (stalled) m_sc = (m_sc == SAT) ? SAT : m_sc + 1;
    if (e.flush) m_fc = (m_fc == SAT) ? SAT : m_fc + 1;
    case (m_st)
      0: if (hif.start_i) m_st = 1;
      1: if (!hif.start_i) m_st = 0;
         else if (hif.Mem_Req_i && !hif.Mem_Ready_i) begin m_st = 2; m_waited = 0; end
      2: begin
        m_waited++;
        if (hif.Mem_Ready_i) m_st = 1;
        else if (m_waited == TO) begin m_st = 3; m_err = 1; end
      end
      default: ;
    endcase
  endtask

  // mode 0: mostly-ready memory; mode 1/2: memory never ready, start toggles
  task automatic drive(input int mode);
    hif.start_i         = (mode == 0) ? ($urandom_range(9) != 0) : 1'($urandom);
    hif.IFID_RS1_Addr_i = 5'($urandom_range(3));
    hif.IFID_RS2_Addr_i = 5'($urandom_range(3));
    hif.IDEX_Rd_Addr_i  = 5'($urandom_range(3));
    hif.IDEX_MemRead_i  = ($urandom_range(9) < 3);
    hif.Branch_Taken_i  = ($urandom_range(3) == 0);
    hif.Mem_Req_i       = (mode == 0) ? ($urandom_range(9) < 3) : 1'b1;
    hif.Mem_Ready_i     = (mode == 0) ? ($urandom_range(9) < 6) : 1'b0;
    if (mode != 0 && m_st == 0) hif.start_i = 1'b1;
  endtask

  task automatic cycle(input bit rst_val, input int mode, input bit mid);
    obs_t e, got;
    @(posedge clk_i);
    if (rst_i) model_step();
    #1;
    if (!mid) rst_i = rst_val;
    drive(mode);
    if (!rst_i) model_reset();
    if (mid) begin
      #2;
      rst_i = 1'b0;
      #1;
      model_reset();
      e   = predict();
      got = sample();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL async_reset: got %h required %h", got, e);
      end
    end
    q.push_back(predict());
  endtask

  always @(negedge clk_i) begin
    obs_t e, got;
    if (q.size() != 0) begin
      e   = q.pop_front();
      got = sample();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t: got %h required %h (pc ifid fl idex bub exm mwb st err sc fc)",
                 $time, got, e);
      end
    end
  end

  initial begin
    bit did_mid;
    drive(0);
    hif.start_i = 1'b0;
    for (int seg = 0; seg < 12; seg++) begin
      int mode;
      mode    = seg % 3;
      did_mid = 0;
      cycle(1'b0, mode, 1'b0);
      cycle(1'b0, mode, 1'b0);
      for (int c = 0; c < ((mode == 0) ? 150 : 40); c++) begin
        if (mode == 2 && !did_mid && m_st == 2 && m_waited == 3) begin
          cycle(1'b1, mode, 1'b1);
          did_mid = 1;
        end else begin
          cycle(1'b1, mode, 1'b0);
        end
      end
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Decides each cycle whether every stage advances, stalls, flushes or freezes.
- Covers load-use hazards, ID-stage branch redirects and multi-cycle data-memory accesses.
- Drives the per-register write enables in place of tying them to start_i, and keeps saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before the error halt
CNT_W, 32, width of the performance counters

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  run enable; 0 parks the pipeline
IFID_RS1_Addr_i  input  5  rs1 of instruction in ID
IFID_RS2_Addr_i  input  5  rs2 of instruction in ID
IDEX_Rd_Addr_i  input  5  rd of instruction in EX
IDEX_MemRead_i  input  1  instruction in EX is a load
Branch_Taken_i  input  1  branch in ID resolved taken
Mem_Req_i  input  1  EX/MEM holds a load or store
Mem_Ready_i  input  1  data memory completes the access this cycle
PCWrite_o  output  1  PC update enable
IFID_Write_o  output  1  IF/ID write enable
IFID_Flush_o  output  1  IF/ID loads a NOP
IDEX_Write_o  output  1  ID/EX write enable
IDEX_Bubble_o  output  1  ID/EX control inputs forced to 0
EXMEM_Write_o  output  1  EX/MEM write enable
MEMWB_Write_o  output  1  MEM/WB write enable
State_o  output  2  current FSM state
Err_o  output  1  sticky memory-timeout error
StallCount_o  output  CNT_W  load-use plus memory-wait stall cycles
FlushCount_o  output  CNT_W  branch flushes

Behaviour:

States (State_o encoding):
- IDLE=00, RUN=01, MEM_WAIT=10, HALT=11.
- Reset (rst_i=0, asynchronous): state IDLE, wait counter 0, Err_o 0, both counters 0.

Transitions, evaluated at the clock edge:
- IDLE -> RUN when start_i=1.
- RUN -> IDLE when start_i=0. Otherwise RUN -> MEM_WAIT when Mem_Req_i=1 and Mem_Ready_i=0.
- MEM_WAIT -> RUN when Mem_Ready_i=1.
- MEM_WAIT -> HALT when the wait counter reaches MEM_TIMEOUT and Mem_Ready_i=0. Err_o is set on the same edge.
- start_i is ignored in MEM_WAIT; the outstanding access always completes first.
- HALT exits only by reset.

Hazard detection (combinational):
- load_use = IDEX_MemRead_i & (IDEX_Rd_Addr_i != 0) & ((IDEX_Rd_Addr_i == IFID_RS1_Addr_i) | (IDEX_Rd_Addr_i == IFID_RS2_Addr_i)).
- rd = x0 never causes a stall.

Outputs (combinational from state and inputs; priority freeze > load-use > flush):
- IDLE, HALT, MEM_WAIT, or RUN with Mem_Req_i & !Mem_Ready_i (freeze): all *_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0.
- RUN with load_use: PCWrite_o=0, IFID_Write_o=0, IDEX_Write_o=1, IDEX_Bubble_o=1, EXMEM_Write_o=1, MEMWB_Write_o=1, IFID_Flush_o=0.
  - The stall lasts exactly 1 cycle, because the bubble clears IDEX_MemRead_i.
- RUN with Branch_Taken_i and no load_use: all writes 1, IFID_Flush_o=1.
- RUN with load_use and Branch_Taken_i together: the stall wins and there is no flush. The branch re-resolves next cycle with forwarded operands.
- RUN otherwise: all writes 1, flush 0, bubble 0.

Wait counter:
- Cleared on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle.
- Compared against MEM_TIMEOUT-1 before the increment, so HALT is entered after exactly MEM_TIMEOUT wait cycles.

Counters (saturate at all-ones, never wrap):
- StallCount_o +1 on each RUN load-use cycle, each RUN freeze cycle and each MEM_WAIT cycle.
- FlushCount_o +1 on each cycle with IFID_Flush_o=1.

Reset mid-operation:
- All state and counters clear immediately, asynchronously.
- Outputs take the IDLE values in the same cycle.

Test Plan:
1. Reset, then start_i=1 with no hazards -> State_o 00 then 01; all writes 1; counters stay 0 over 10 cycles.
2. IDEX_MemRead_i=1, IDEX_Rd_Addr_i=5, IFID_RS2_Addr_i=5 -> one cycle of PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; StallCount_o=1. Repeat with Rd=0 -> no stall.
3. Branch_Taken_i=1 with no hazard -> IFID_Flush_o=1 for one cycle; FlushCount_o=1. Branch_Taken_i together with load-use -> stall only; FlushCount_o unchanged.
4. Mem_Req_i=1 with Mem_Ready_i low for 3 cycles -> State_o 10; all writes 0 throughout; resumes RUN on the ready edge; StallCount_o=4 (3 MEM_WAIT cycles plus the entry freeze cycle).
5. Mem_Ready_i held 0 for 16 cycles -> HALT (11), Err_o=1, writes 0. start_i toggling has no effect; reset -> IDLE, Err_o=0.
6. rst_i asserted low mid-MEM_WAIT -> State_o=00, counters 0, all writes 0 immediately, without waiting for a clock edge.
